// File: rtl/wb_regfile.sv
// Write-back stage and 2^ADDR_W x DATA_W register file.
// Selects the write-back value, commits it, and serves two bypassed read ports plus registered write-back info.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemToReg_i,
  input  logic              RegWrite_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [DATA_W-1:0] immed_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic [ADDR_W-1:0] WBaddr_q_o,
  output logic [DATA_W-1:0] WBdata_q_o,
  output logic              WBvalid_q_o,
  output logic [CNT_W-1:0]  wb_count_o
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];

  logic              we_c;
  logic [DATA_W-1:0] wb_data_c;

  logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic [CNT_W-1:0]  wb_count_q, wb_count_d;

  // Write-back select and commit qualifier; r0 writes are discarded entirely.
  assign wb_data_c = MemToReg_i ? ReadData_i : immed_i;
  assign we_c      = RegWrite_i && (RDaddr_i != '0);
  assign WBdata_o  = wb_data_c;

  // Read ports with write-through bypass of the write committing this cycle.
  always_comb begin
    RSdata_o = regs_q[RSaddr_i];
    if (RSaddr_i == '0) begin
      RSdata_o = '0;
    end else if (we_c && (RSaddr_i == RDaddr_i)) begin
      RSdata_o = wb_data_c;
    end

    RTdata_o = regs_q[RTaddr_i];
    if (RTaddr_i == '0) begin
      RTdata_o = '0;
    end else if (we_c && (RTaddr_i == RDaddr_i)) begin
      RTdata_o = wb_data_c;
    end
  end

  // Register array; reset wins over a simultaneous write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_c) begin
      regs_q[RDaddr_i] <= wb_data_c;
    end
  end

  // Forwarding info and retired-write counter next state.
  always_comb begin
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    wb_count_d = wb_count_q;
    if (we_c) begin
      wb_addr_d  = RDaddr_i;
      wb_data_d  = wb_data_c;
      wb_valid_d = 1'b1;
      wb_count_d = wb_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_count_q <= '0;
    end else begin
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      wb_count_q <= wb_count_d;
    end
  end

  assign WBaddr_q_o  = wb_addr_q;
  assign WBdata_q_o  = wb_data_q;
  assign WBvalid_q_o = wb_valid_q;
  assign wb_count_o  = wb_count_q;

endmodule
